mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared instruction/data memory port arbiter
// Data accesses win over fetches; every access is bounded by a TIMEOUT-cycle ack watchdog.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        stall_mem,
  output logic        PCwrite,
  output logic        if_id_write,
  output logic        err
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_fetch_dropped;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [31:0]        r_if_rdata;
  logic               r_if_ready;
  logic [31:0]        r_d_rdata;
  logic               r_d_ready;
  logic               r_err;

  logic w_start_data;
  logic w_start_fetch;
  logic w_ack_done;
  logic w_abort;
  logic w_timeout;
  logic w_stall;
  logic w_pc_write;

  assign w_timeout  = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  assign w_stall    = (d_read | d_write) & ~r_d_ready;
  assign w_pc_write = r_if_ready & ~w_stall & ~if_flush;

  // A data request still visible during its own d_ready cycle is the one just served.
  always_comb begin
    w_next_state  = r_state;
    w_start_data  = 1'b0;
    w_start_fetch = 1'b0;
    w_ack_done    = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      IDLE: begin
        if ((d_read | d_write) & ~r_d_ready) begin
          w_next_state = DATA;
          w_start_data = 1'b1;
        end else if (if_req & ~r_if_ready & ~if_flush) begin
          w_next_state  = FETCH;
          w_start_fetch = 1'b1;
        end
      end
      DATA, FETCH: begin
        if (mem_ack) begin
          w_next_state = IDLE;
          w_ack_done   = 1'b1;
        end else if (w_timeout) begin
          w_next_state = IDLE;
          w_abort      = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt      <= '0;
      r_fetch_dropped <= 1'b0;
      r_mem_en        <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_if_rdata      <= '0;
      r_if_ready      <= 1'b0;
      r_d_rdata       <= '0;
      r_d_ready       <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_d_ready <= 1'b0;
      if (w_pc_write || if_flush) r_if_ready <= 1'b0;
      if (if_flush) r_fetch_dropped <= 1'b1;
      if ((r_state != IDLE) && !mem_ack && !w_timeout) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_start_data) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= d_write;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
        r_wait_cnt  <= '0;
      end
      if (w_start_fetch) begin
        r_mem_en        <= 1'b1;
        r_mem_we        <= 1'b0;
        r_mem_addr      <= if_addr;
        r_wait_cnt      <= '0;
        r_fetch_dropped <= 1'b0;
      end
      if (w_ack_done || w_abort) begin
        r_mem_en <= 1'b0;
        r_mem_we <= 1'b0;
      end
      if (w_ack_done && (r_state == DATA)) begin
        r_d_ready <= 1'b1;
        if (!r_mem_we) r_d_rdata <= mem_rdata;
      end
      if (w_ack_done && (r_state == FETCH) && !r_fetch_dropped && !if_flush) begin
        r_if_rdata <= mem_rdata;
        r_if_ready <= 1'b1;
      end
      if (w_abort) begin
        r_err <= 1'b1;
        if (r_state == DATA) begin
          r_d_ready <= 1'b1;
          r_d_rdata <= '0;
        end
      end
    end
  end

  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign if_rdata    = r_if_rdata;
  assign if_ready    = r_if_ready;
  assign d_rdata     = r_d_rdata;
  assign d_ready     = r_d_ready;
  assign err         = r_err;
  assign stall_mem   = w_stall;
  assign PCwrite     = w_pc_write;
  assign if_id_write = w_pc_write;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a memory/latency model
module tb_mem_arbiter;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, d_read, d_write, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        mem_en, mem_we, if_ready, d_ready, stall_mem, PCwrite, if_id_write, err;
  logic [31:0] mem_addr, mem_wdata, if_rdata, d_rdata;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mem_arr [256];
  int          lat;
  int          k;
  logic        manual_mode, manual_ack;
  logic [31:0] manual_rdata;
  logic [31:0] exp_d_rdata, exp_if_rdata;
  logic        exp_err;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_rdata(d_rdata), .d_ready(d_ready), .stall_mem(stall_mem), .PCwrite(PCwrite),
    .if_id_write(if_id_write), .err(err)
  );

  always #5 clk = ~clk;

  // Memory responder: acks on the lat-th cycle of an access (0 = first cycle mem_en is seen).
  always begin
    @(posedge clk);
    #1;
    if (manual_mode) begin
      mem_ack   = manual_ack;
      mem_rdata = manual_rdata;
      k         = 0;
    end else if (mem_en) begin
      mem_ack   = (k == lat);
      mem_rdata = ((k == lat) && !mem_we) ? mem_arr[mem_addr[9:2]] : $urandom;
      k         = k + 1;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      k         = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_data(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input int lt);
    int          n_en;
    int          exp_n;
    bit          done;
    logic [31:0] exp_rd;
    lat   = lt;
    exp_n = (lt < TO) ? lt + 1 : TO;
    if (lt >= TO) begin
      exp_rd  = 32'h0;
      exp_err = 1'b1;
    end else begin
      exp_rd = wr ? exp_d_rdata : mem_arr[addr[9:2]];
    end
    d_write = wr;
    d_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    d_addr  = addr;
    d_wdata = wdata;
    #1 check_eq("d_stall_req", stall_mem, 1);
    n_en = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      cyc();
      if (mem_en) begin
        n_en++;
        check_eq("d_addr_hold", mem_addr, addr);
        check_eq("d_we_hold", mem_we, wr);
        if (wr) check_eq("d_wdata_hold", mem_wdata, wdata);
        check_eq("d_stall_busy", stall_mem, 1);
      end else begin
        done = 1;
        check_eq("d_ready_pulse", d_ready, 1);
        check_eq("d_rdata", d_rdata, exp_rd);
        check_eq("d_en_cycles", n_en, exp_n);
        check_eq("d_stall_done", stall_mem, 0);
        check_eq("d_err", err, exp_err);
      end
    end
    check_eq("d_done", done, 1);
    d_read  = 1'b0;
    d_write = 1'b0;
    cyc();
    check_eq("d_ready_low", d_ready, 0);
    check_eq("d_en_low", mem_en, 0);
    exp_d_rdata = exp_rd;
    if (wr && lt < TO) mem_arr[addr[9:2]] = wdata;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int lt, input int flush_at);
    int  n_en;
    int  exp_n;
    bit  done;
    bit  exp_ok;
    lat    = lt;
    exp_n  = (lt < TO) ? lt + 1 : TO;
    exp_ok = (lt < TO) && (flush_at < 0);
    if (lt >= TO) exp_err = 1'b1;
    if (exp_ok) exp_if_rdata = mem_arr[addr[9:2]];
    if_req  = 1'b1;
    if_addr = addr;
    n_en = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      cyc();
      if (mem_en) begin
        check_eq("f_addr_hold", mem_addr, addr);
        check_eq("f_we", mem_we, 0);
        if_flush = (n_en == flush_at);
        n_en++;
        #1 check_eq("f_pcwrite_busy", PCwrite, 0);
      end else begin
        done     = 1;
        if_flush = 1'b0;
        check_eq("f_en_cycles", n_en, exp_n);
        check_eq("f_ready", if_ready, exp_ok);
        check_eq("f_rdata", if_rdata, exp_if_rdata);
        check_eq("f_err", err, exp_err);
        #1;
        check_eq("f_pcwrite", PCwrite, exp_ok);
        check_eq("f_ifid_write", if_id_write, exp_ok);
      end
    end
    check_eq("f_done", done, 1);
    if_req = 1'b0;
    cyc();
    check_eq("f_ready_clr", if_ready, 0);
    check_eq("f_en_low", mem_en, 0);
    #1 check_eq("f_pcwrite_low", PCwrite, 0);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; d_read = 1'b0; d_write = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    manual_mode = 1'b0; manual_ack = 1'b0; manual_rdata = '0;
    lat = 0; k = 0; mem_ack = 1'b0; mem_rdata = '0;
    exp_d_rdata = '0; exp_if_rdata = '0; exp_err = 1'b0;
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;

    cyc(); cyc();
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_if_ready", if_ready, 0);
    check_eq("rst_d_ready", d_ready, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_pcwrite", PCwrite, 0);
    check_eq("rst_stall", stall_mem, 0);
    rst = 1'b0;
    cyc();

    // Fetch with ack two cycles after grant
    mem_arr[8'h40] = 32'h2002000A;
    do_fetch(32'h100, 2, -1);
    check_eq("fetch_word", if_rdata, 32'h2002000A);

    // Simultaneous fetch and load: data goes first
    mem_arr[8'h10] = 32'h0000DEAD;
    lat = 1;
    if_req = 1'b1; if_addr = 32'h200; d_read = 1'b1; d_addr = 32'h40;
    #1 check_eq("prio_stall0", stall_mem, 1);
    cyc();
    check_eq("prio_data_en", mem_en, 1);
    check_eq("prio_data_addr", mem_addr, 32'h40);
    check_eq("prio_data_we", mem_we, 0);
    check_eq("prio_stall1", stall_mem, 1);
    cyc();
    check_eq("prio_wait_en", mem_en, 1);
    cyc();
    check_eq("prio_d_ready", d_ready, 1);
    check_eq("prio_d_rdata", d_rdata, 32'h0000DEAD);
    check_eq("prio_stall_done", stall_mem, 0);
    lat = 0; d_read = 1'b0;
    cyc();
    check_eq("prio_fetch_en", mem_en, 1);
    check_eq("prio_fetch_addr", mem_addr, 32'h200);
    cyc();
    check_eq("prio_if_ready", if_ready, 1);
    check_eq("prio_if_rdata", if_rdata, mem_arr[8'h80]);
    #1 check_eq("prio_pcwrite", PCwrite, 1);
    if_req = 1'b0;
    cyc();
    check_eq("prio_if_clr", if_ready, 0);
    exp_d_rdata = 32'h0000DEAD; exp_if_rdata = mem_arr[8'h80];

    // Store leaves load data untouched
    do_data(1'b1, 32'h80, 32'h1234, 3);
    check_eq("store_keeps_rdata", d_rdata, 32'h0000DEAD);

    // Flush during fetch, then the held request refetches
    lat = 3; if_req = 1'b1; if_addr = 32'h300;
    cyc();
    check_eq("fl_en", mem_en, 1);
    check_eq("fl_addr", mem_addr, 32'h300);
    cyc();
    if_flush = 1'b1;
    #1 check_eq("fl_pcwrite", PCwrite, 0);
    cyc();
    if_flush = 1'b0;
    check_eq("fl_en_mid", mem_en, 1);
    cyc();
    lat = 0;
    cyc();
    check_eq("fl_idle", mem_en, 0);
    check_eq("fl_dropped", if_ready, 0);
    check_eq("fl_if_rdata", if_rdata, exp_if_rdata);
    #1 check_eq("fl_pcwrite_idle", PCwrite, 0);
    cyc();
    check_eq("fl_refetch_en", mem_en, 1);
    check_eq("fl_refetch_addr", mem_addr, 32'h300);
    cyc();
    check_eq("fl_refetch_ready", if_ready, 1);
    check_eq("fl_refetch_rdata", if_rdata, mem_arr[8'hC0]);
    if_req = 1'b0;
    cyc();
    check_eq("fl_refetch_clr", if_ready, 0);
    exp_if_rdata = mem_arr[8'hC0];

    // Flush while the buffer is valid clears it without a new fetch
    lat = 0; if_req = 1'b1; if_addr = 32'h104;
    cyc();
    cyc();
    check_eq("rf_ready", if_ready, 1);
    if_flush = 1'b1;
    #1 check_eq("rf_pcwrite", PCwrite, 0);
    cyc();
    check_eq("rf_clr", if_ready, 0);
    check_eq("rf_no_fetch", mem_en, 0);
    if_flush = 1'b0; if_req = 1'b0;
    cyc();
    exp_if_rdata = mem_arr[8'h41];

    // Load held past d_ready becomes a second access
    lat = 0; d_read = 1'b1; d_addr = 32'h48;
    cyc();
    check_eq("hold_en1", mem_en, 1);
    cyc();
    check_eq("hold_ready1", d_ready, 1);
    cyc();
    check_eq("hold_gap_en", mem_en, 0);
    check_eq("hold_gap_ready", d_ready, 0);
    check_eq("hold_gap_stall", stall_mem, 1);
    cyc();
    check_eq("hold_en2", mem_en, 1);
    check_eq("hold_addr2", mem_addr, 32'h48);
    cyc();
    check_eq("hold_ready2", d_ready, 1);
    check_eq("hold_rdata2", d_rdata, mem_arr[8'h12]);
    d_read = 1'b0;
    cyc();
    check_eq("hold_end", d_ready, 0);
    exp_d_rdata = mem_arr[8'h12];

    // Watchdog abort, err stays set across a later good access
    do_data(1'b0, 32'h50, 32'h0, 1000);
    do_data(1'b0, 32'h54, 32'h0, 1);
    check_eq("err_sticky", err, 1);

    // Reset in the middle of a pending access, then a stray ack
    lat = 1000; d_read = 1'b1; d_addr = 32'h58;
    cyc(); cyc(); cyc();
    check_eq("rsta_en", mem_en, 1);
    rst = 1'b1; d_read = 1'b0;
    manual_mode = 1'b1; manual_ack = 1'b1; manual_rdata = 32'hFFFF0000;
    cyc();
    check_eq("rsta_mem_en", mem_en, 0);
    check_eq("rsta_mem_we", mem_we, 0);
    check_eq("rsta_mem_addr", mem_addr, 0);
    check_eq("rsta_mem_wdata", mem_wdata, 0);
    check_eq("rsta_if_rdata", if_rdata, 0);
    check_eq("rsta_d_rdata", d_rdata, 0);
    check_eq("rsta_d_ready", d_ready, 0);
    check_eq("rsta_err", err, 0);
    rst = 1'b0;
    cyc();
    check_eq("late_ack_ready", d_ready, 0);
    check_eq("late_ack_rdata", d_rdata, 0);
    check_eq("late_ack_en", mem_en, 0);
    check_eq("late_ack_if", if_ready, 0);
    manual_mode = 1'b0; manual_ack = 1'b0;
    cyc();
    exp_d_rdata = '0; exp_if_rdata = '0; exp_err = 1'b0;

    for (int i = 0; i < 80; i++) begin
      int op;
      int sel;
      int lt;
      op  = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      if (sel < 6)      lt = $urandom_range(0, 4);
      else if (sel < 8) lt = TO - 1;
      else              lt = 1000;
      case (op)
        0:       do_data(1'b0, $urandom, 32'h0, lt);
        1:       do_data(1'b1, $urandom, $urandom, lt);
        2:       do_fetch($urandom, lt, -1);
        default: do_fetch($urandom, lt, $urandom_range(0, (lt < TO) ? lt : TO - 1));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
